axis_width_upsizer: RTL and testbench



---
 rtl/axis_width_upsizer.sv | 178 +++++++++++++++++
 tb/tb_axis_width_upsizer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_upsizer.sv
// AXI-Stream width up-converter: packs NSIZE slim beats into one wide beat.
// Optional per-lane tuser packing is enabled by defining AXIS_UPSIZER_TUSER_EN.
module axis_width_upsizer #(
    parameter int SLIM_DSIZE = 8,
    parameter int NSIZE      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int USIZE      = 1
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [SLIM_DSIZE-1:0]         slim_tdata,
    input  logic [SLIM_DSIZE/8-1:0]       slim_tkeep,
    input  logic                          slim_tvalid,
    input  logic                          slim_tlast,
    output logic                          slim_tready,
`ifdef AXIS_UPSIZER_TUSER_EN
    input  logic [USIZE-1:0]              slim_tuser,
    output logic [USIZE*NSIZE-1:0]        wide_tuser,
`endif
    output logic [SLIM_DSIZE*NSIZE-1:0]   wide_tdata,
    output logic [SLIM_DSIZE/8*NSIZE-1:0] wide_tkeep,
    output logic                          wide_tvalid,
    output logic                          wide_tlast,
    input  logic                          wide_tready
);

    localparam int KSIZE = SLIM_DSIZE / 8;
    localparam int CW    = $clog2(NSIZE);
    localparam int WD    = SLIM_DSIZE * NSIZE;
    localparam int WK    = KSIZE * NSIZE;

    // Reject configurations the lane arithmetic cannot represent.
    if (SLIM_DSIZE < 8 || (SLIM_DSIZE % 8) != 0) begin : g_bad_dsize
        $error("SLIM_DSIZE must be a non-zero multiple of 8");
    end
    if (NSIZE < 2) begin : g_bad_nsize
        $error("NSIZE must be at least 2");
    end
    if (USIZE < 1) begin : g_bad_usize
        $error("USIZE must be at least 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WD-1:0] acc_data_q, acc_data_d;
    logic [WK-1:0] acc_keep_q, acc_keep_d;
    logic [WD-1:0] out_data_q, out_data_d;
    logic [WK-1:0] out_keep_q, out_keep_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic [CW-1:0] lane;
    logic          last_lane;
    logic          completing;
    logic          accept;
    logic          load;
    logic [WD-1:0] mrg_data;
    logic [WK-1:0] mrg_keep;

    // Lane selection, completion detection and handshake qualification.
    always_comb begin
        lane = cnt_q;
        if (MSB_FIRST != 0) begin
            lane = CW'(NSIZE - 1) - cnt_q;
        end
        last_lane   = (cnt_q == CW'(NSIZE - 1));
        completing  = last_lane || slim_tlast;
        slim_tready = rst_n &&
                      (!completing || !out_valid_q || wide_tready);
        accept      = slim_tvalid && slim_tready;
        load        = accept && completing;
    end

    // Accumulator contents with the current beat dropped into its lane.
    always_comb begin
        mrg_data = acc_data_q;
        mrg_keep = acc_keep_q;
        mrg_data[int'(lane)*SLIM_DSIZE +: SLIM_DSIZE] = slim_tdata;
        mrg_keep[int'(lane)*KSIZE +: KSIZE]           = slim_tkeep;
    end

    // Accumulator next state: collect beats, clear once a word is handed off.
    always_comb begin
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        if (accept) begin
            if (completing) begin
                cnt_d      = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                acc_data_d = mrg_data;
                acc_keep_d = mrg_keep;
            end
        end
    end

    // Output register next state: drain on handshake, a new load takes priority.
    always_comb begin
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (out_valid_q && wide_tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (load) begin
            out_data_d  = mrg_data;
            out_keep_d  = mrg_keep;
            out_valid_d = 1'b1;
            out_last_d  = slim_tlast;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign wide_tdata  = out_data_q;
    assign wide_tkeep  = out_keep_q;
    assign wide_tvalid = out_valid_q;
    assign wide_tlast  = out_last_q;

`ifdef AXIS_UPSIZER_TUSER_EN
    localparam int WU = USIZE * NSIZE;

    logic [WU-1:0] acc_user_q, acc_user_d;
    logic [WU-1:0] out_user_q, out_user_d;
    logic [WU-1:0] mrg_user;

    // tuser follows the same lane packing and clearing as tdata.
    always_comb begin
        mrg_user = acc_user_q;
        mrg_user[int'(lane)*USIZE +: USIZE] = slim_tuser;
        acc_user_d = acc_user_q;
        out_user_d = out_user_q;
        if (accept) begin
            acc_user_d = completing ? '0 : mrg_user;
        end
        if (load) begin
            out_user_d = mrg_user;
        end
    end

    // tuser registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            acc_user_q <= '0;
            out_user_q <= '0;
        end else begin
            acc_user_q <= acc_user_d;
            out_user_q <= out_user_d;
        end
    end

    assign wide_tuser = out_user_q;
`endif

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed bench for axis_width_upsizer: one MSB-first and one LSB-first
// instance share stimulus; expected values are hand-computed per step.
module tb_axis_width_upsizer;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        k;
        logic        l;
        logic        wr;
        logic        er;
        logic        ev;
        logic        el;
        logic [31:0] edm;
        logic [3:0]  ekm;
        logic [31:0] edl;
        logic [3:0]  ekl;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = '0;
    logic [0:0]  s_keep = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        w_ready = 1'b0;
    logic        rdy_m, rdy_l;
    logic [31:0] dat_m, dat_l;
    logic [3:0]  kp_m, kp_l;
    logic        val_m, val_l;
    logic        lst_m, lst_l;
`ifdef AXIS_UPSIZER_TUSER_EN
    logic [1:0]  s_user = '0;
    logic [7:0]  usr_m, usr_l;
`endif

    int tests = 0;
    int fails = 0;
    int stepno = 0;

    always #5 clock = ~clock;

    axis_width_upsizer #(
        .SLIM_DSIZE(8), .NSIZE(4), .MSB_FIRST(1), .USIZE(2)
    ) u_m (
        .clock(clock), .rst_n(rst_n),
        .slim_tdata(s_data), .slim_tkeep(s_keep),
        .slim_tvalid(s_valid), .slim_tlast(s_last),
        .slim_tready(rdy_m),
`ifdef AXIS_UPSIZER_TUSER_EN
        .slim_tuser(s_user), .wide_tuser(usr_m),
`endif
        .wide_tdata(dat_m), .wide_tkeep(kp_m),
        .wide_tvalid(val_m), .wide_tlast(lst_m),
        .wide_tready(w_ready)
    );

    axis_width_upsizer #(
        .SLIM_DSIZE(8), .NSIZE(4), .MSB_FIRST(0), .USIZE(2)
    ) u_l (
        .clock(clock), .rst_n(rst_n),
        .slim_tdata(s_data), .slim_tkeep(s_keep),
        .slim_tvalid(s_valid), .slim_tlast(s_last),
        .slim_tready(rdy_l),
`ifdef AXIS_UPSIZER_TUSER_EN
        .slim_tuser(s_user), .wide_tuser(usr_l),
`endif
        .wide_tdata(dat_l), .wide_tkeep(kp_l),
        .wide_tvalid(val_l), .wide_tlast(lst_l),
        .wide_tready(w_ready)
    );

    function automatic vec_t mk(
        input logic r, v, input logic [7:0] d,
        input logic k, l, wr, er, ev, el,
        input logic [31:0] edm, input logic [3:0] ekm,
        input logic [31:0] edl, input logic [3:0] ekl);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.k = k; t.l = l; t.wr = wr;
        t.er = er; t.ev = ev; t.el = el;
        t.edm = edm; t.ekm = ekm; t.edl = edl; t.ekl = ekl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h, expected %h",
                     name, stepno, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        @(negedge clock);
        rst_n   = t.r;
        s_valid = t.v;
        s_data  = t.d;
        s_keep  = t.k;
        s_last  = t.l;
        w_ready = t.wr;
        #1;
        chk("ready_msb", {31'b0, rdy_m}, {31'b0, t.er});
        chk("ready_lsb", {31'b0, rdy_l}, {31'b0, t.er});
        @(posedge clock);
        #1;
        chk("valid_msb", {31'b0, val_m}, {31'b0, t.ev});
        chk("valid_lsb", {31'b0, val_l}, {31'b0, t.ev});
        chk("last_msb", {31'b0, lst_m}, {31'b0, t.el});
        chk("last_lsb", {31'b0, lst_l}, {31'b0, t.el});
        chk("data_msb", dat_m, t.edm);
        chk("keep_msb", {28'b0, kp_m}, {28'b0, t.ekm});
        chk("data_lsb", dat_l, t.edl);
        chk("keep_lsb", {28'b0, kp_l}, {28'b0, t.ekl});
        stepno++;
    endtask

    vec_t tbl[$];

    initial begin
        // reset
        tbl.push_back(mk(0,0,8'h00,0,0,1, 0, 0,0,32'h0,4'h0,32'h0,4'h0));
        // full word 11,22,33,44
        tbl.push_back(mk(1,1,8'h11,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        tbl.push_back(mk(1,1,8'h22,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        tbl.push_back(mk(1,1,8'h33,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        tbl.push_back(mk(1,1,8'h44,1,1,1, 1, 1,1,
                         32'h11223344,4'hF,32'h44332211,4'hF));
        // partial word AA,BB
        tbl.push_back(mk(1,1,8'hAA,1,0,1, 1, 0,0,
                         32'h11223344,4'hF,32'h44332211,4'hF));
        tbl.push_back(mk(1,1,8'hBB,1,1,1, 1, 1,1,
                         32'hAABB0000,4'hC,32'h0000BBAA,4'h3));
        // back-to-back frames of 5 and 3 beats
        tbl.push_back(mk(1,1,8'h01,1,0,1, 1, 0,0,
                         32'hAABB0000,4'hC,32'h0000BBAA,4'h3));
        tbl.push_back(mk(1,1,8'h02,1,0,1, 1, 0,0,
                         32'hAABB0000,4'hC,32'h0000BBAA,4'h3));
        tbl.push_back(mk(1,1,8'h03,1,0,1, 1, 0,0,
                         32'hAABB0000,4'hC,32'h0000BBAA,4'h3));
        tbl.push_back(mk(1,1,8'h04,1,0,1, 1, 1,0,
                         32'h01020304,4'hF,32'h04030201,4'hF));
        tbl.push_back(mk(1,1,8'h05,1,1,1, 1, 1,1,
                         32'h05000000,4'h8,32'h00000005,4'h1));
        tbl.push_back(mk(1,1,8'h06,1,0,1, 1, 0,0,
                         32'h05000000,4'h8,32'h00000005,4'h1));
        tbl.push_back(mk(1,1,8'h07,1,0,1, 1, 0,0,
                         32'h05000000,4'h8,32'h00000005,4'h1));
        tbl.push_back(mk(1,1,8'h08,1,1,1, 1, 1,1,
                         32'h06070800,4'hE,32'h00080706,4'h7));
        // single-beat frame straight after a load
        tbl.push_back(mk(1,1,8'h5A,1,1,1, 1, 1,1,
                         32'h5A000000,4'h8,32'h0000005A,4'h1));
        // zero keep carried through, word closed by count only
        tbl.push_back(mk(1,1,8'hC1,1,0,1, 1, 0,0,
                         32'h5A000000,4'h8,32'h0000005A,4'h1));
        tbl.push_back(mk(1,1,8'hC2,0,0,1, 1, 0,0,
                         32'h5A000000,4'h8,32'h0000005A,4'h1));
        tbl.push_back(mk(1,1,8'hC3,1,0,1, 1, 0,0,
                         32'h5A000000,4'h8,32'h0000005A,4'h1));
        tbl.push_back(mk(1,1,8'hC4,0,0,1, 1, 1,0,
                         32'hC1C2C3C4,4'hA,32'hC4C3C2C1,4'h5));
        // tlast on the word boundary, no trailing empty word
        tbl.push_back(mk(1,1,8'hD1,1,0,1, 1, 0,0,
                         32'hC1C2C3C4,4'hA,32'hC4C3C2C1,4'h5));
        tbl.push_back(mk(1,1,8'hD2,1,0,1, 1, 0,0,
                         32'hC1C2C3C4,4'hA,32'hC4C3C2C1,4'h5));
        tbl.push_back(mk(1,1,8'hD3,1,0,1, 1, 0,0,
                         32'hC1C2C3C4,4'hA,32'hC4C3C2C1,4'h5));
        tbl.push_back(mk(1,1,8'hD4,1,1,1, 1, 1,1,
                         32'hD1D2D3D4,4'hF,32'hD4D3D2D1,4'hF));
        tbl.push_back(mk(1,0,8'h00,0,0,1, 1, 0,0,
                         32'hD1D2D3D4,4'hF,32'hD4D3D2D1,4'hF));

        foreach (tbl[i]) step(tbl[i]);

        // back-pressure: first word held, three beats absorbed, fourth stalls
        step(mk(1,1,8'hE1,1,0,0, 1, 0,0,
                32'hD1D2D3D4,4'hF,32'hD4D3D2D1,4'hF));
        step(mk(1,1,8'hE2,1,0,0, 1, 0,0,
                32'hD1D2D3D4,4'hF,32'hD4D3D2D1,4'hF));
        step(mk(1,1,8'hE3,1,0,0, 1, 0,0,
                32'hD1D2D3D4,4'hF,32'hD4D3D2D1,4'hF));
        step(mk(1,1,8'hE4,1,0,0, 1, 1,0,
                32'hE1E2E3E4,4'hF,32'hE4E3E2E1,4'hF));
        step(mk(1,1,8'hF1,1,0,0, 1, 1,0,
                32'hE1E2E3E4,4'hF,32'hE4E3E2E1,4'hF));
        step(mk(1,1,8'hF2,1,0,0, 1, 1,0,
                32'hE1E2E3E4,4'hF,32'hE4E3E2E1,4'hF));
        step(mk(1,1,8'hF3,1,0,0, 1, 1,0,
                32'hE1E2E3E4,4'hF,32'hE4E3E2E1,4'hF));
        step(mk(1,1,8'hF4,1,0,0, 0, 1,0,
                32'hE1E2E3E4,4'hF,32'hE4E3E2E1,4'hF));
        step(mk(1,1,8'hF4,1,0,1, 1, 1,0,
                32'hF1F2F3F4,4'hF,32'hF4F3F2F1,4'hF));
        step(mk(1,0,8'h00,0,0,1, 1, 0,0,
                32'hF1F2F3F4,4'hF,32'hF4F3F2F1,4'hF));

        // reset mid-frame discards the partial word
        step(mk(1,1,8'h71,1,0,1, 1, 0,0,
                32'hF1F2F3F4,4'hF,32'hF4F3F2F1,4'hF));
        step(mk(1,1,8'h72,1,0,1, 1, 0,0,
                32'hF1F2F3F4,4'hF,32'hF4F3F2F1,4'hF));
        step(mk(0,1,8'h73,1,0,1, 0, 0,0,32'h0,4'h0,32'h0,4'h0));
        step(mk(1,1,8'h81,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        step(mk(1,1,8'h82,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        step(mk(1,1,8'h83,1,0,1, 1, 0,0,32'h0,4'h0,32'h0,4'h0));
        step(mk(1,1,8'h84,1,1,1, 1, 1,1,
                32'h81828384,4'hF,32'h84838281,4'hF));
        step(mk(1,0,8'h00,0,0,1, 1, 0,0,
                32'h81828384,4'hF,32'h84838281,4'hF));

`ifdef AXIS_UPSIZER_TUSER_EN
        // tuser packing 1,2,3,0
        s_user = 2'd1;
        step(mk(1,1,8'h91,1,0,1, 1, 0,0,
                32'h81828384,4'hF,32'h84838281,4'hF));
        s_user = 2'd2;
        step(mk(1,1,8'h92,1,0,1, 1, 0,0,
                32'h81828384,4'hF,32'h84838281,4'hF));
        s_user = 2'd3;
        step(mk(1,1,8'h93,1,0,1, 1, 0,0,
                32'h81828384,4'hF,32'h84838281,4'hF));
        s_user = 2'd0;
        step(mk(1,1,8'h94,1,1,1, 1, 1,1,
                32'h91929394,4'hF,32'h94939291,4'hF));
        chk("user_msb", {24'b0, usr_m}, 32'h6C);
        chk("user_lsb", {24'b0, usr_l}, 32'h39);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
